pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/aes_ctrl_pkg.sv | 13 +
 rtl/hold_counter.sv | 27 ++
 rtl/pulse_stretcher.sv | 79 +++++++
 tb/tb_pulse_stretcher.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and default counter width.
package aes_ctrl_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/hold_counter.sv
// Hold-length down-counter: loads on acceptance, decrements toward 1 and never wraps.
module hold_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt > CNT_W'(1))) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Converts a single-cycle request into a level held for a minimum length and until acknowledged.
module pulse_stretcher
    import aes_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] hold_len,
    input  logic             ack,
    input  logic             clr_err,
    output logic             level_out,
    output logic             done,
    output logic             overrun
);

    state_t           state, state_nxt;
    logic             ack_seen, ack_seen_nxt;
    logic             load, dec, is_one;
    logic [CNT_W-1:0] load_val;

    // A zero length still produces a one-cycle level.
    assign load_val = (hold_len == '0) ? CNT_W'(1) : hold_len;

    hold_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .is_one   (is_one)
    );

    always_comb begin
        state_nxt    = state;
        ack_seen_nxt = ack_seen;
        load         = 1'b0;
        dec          = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nxt    = HOLD;
                    load         = 1'b1;
                    ack_seen_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (ack) ack_seen_nxt = 1'b1;
                if (is_one) state_nxt = (ack_seen || ack) ? RELEASE : WAIT_ACK;
                else        dec       = 1'b1;
            end
            WAIT_ACK: begin
                if (ack) state_nxt = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered off the next state so level_out rises one cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ack_seen  <= 1'b0;
            level_out <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_seen  <= ack_seen_nxt;
            level_out <= (state_nxt == HOLD) || (state_nxt == WAIT_ACK);
            done      <= (state_nxt == RELEASE);
            if (pulse_in && (state != IDLE)) overrun <= 1'b1;
            else if (clr_err)                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: expected outputs are queued as each cycle is driven and checked after the edge.
module tb_pulse_stretcher;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pulse_in, ack, clr_err;
    logic [CNT_W-1:0] hold_len;
    logic             level_out, done, overrun;

    typedef struct {
        logic lvl;
        logic dn;
        logic ovr;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic exp_ovr = 1'b0;

    pulse_stretcher #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .hold_len  (hold_len),
        .ack       (ack),
        .clr_err   (clr_err),
        .level_out (level_out),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, " queue_empty"}, 1'b1, 1'b0);
        end else begin
            e = q.pop_front();
            chk({tag, " level_out"}, level_out, e.lvl);
            chk({tag, " done"},      done,      e.dn);
            chk({tag, " overrun"},   overrun,   e.ovr);
        end
    endtask

    task automatic cyc(input logic p, input logic a, input logic c, input logic [CNT_W-1:0] h,
                       input logic el, input logic ed, input logic eo, input string tag);
        pulse_in = p;
        ack      = a;
        clr_err  = c;
        hold_len = h;
        q.push_back('{el, ed, eo});
        @(posedge clk);
        #1;
        pop_cmp(tag);
    endtask

    // One request from acceptance (cycle 0) to release plus idle tail.
    // ack_hold=1: ack stays high from ack_at on; ack_hold=0: single ack pulse at ack_at.
    // Release cycle is one past the later of the last HOLD cycle and the ack cycle.
    task automatic run(input string tag, input int h, input int ack_at, input bit ack_hold,
                       input int drop1, input int drop2, input int clr_at, input int tail);
        int hh, rel;
        logic p, a, c;
        logic [CNT_W-1:0] hv;
        hh  = (h == 0) ? 1 : h;
        rel = ((ack_at <= hh) ? hh : ack_at) + 1;
        for (int cy = 0; cy <= rel + tail; cy++) begin
            p  = (cy == 0) || (cy == drop1) || (cy == drop2);
            a  = ack_hold ? (cy >= ack_at) : (cy == ack_at);
            c  = (cy == clr_at);
            hv = (cy == 0) ? CNT_W'(h) : CNT_W'($urandom_range(0, 255));
            if (p && cy >= 1 && cy <= rel) exp_ovr = 1'b1;
            else if (c)                    exp_ovr = 1'b0;
            cyc(p, a, c, hv, (cy + 1 >= 1) && (cy + 1 < rel), (cy + 1 == rel), exp_ovr,
                $sformatf("%s c%0d", tag, cy + 1));
        end
    endtask

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b0;
        ack      = 1'b0;
        clr_err  = 1'b0;
        hold_len = '0;
        q.push_back('{1'b0, 1'b0, 1'b0});
        #2;
        pop_cmp("reset_t0");
        cyc(1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, "reset_hold0");
        cyc(1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, "reset_hold1");
        rst = 1'b0;

        // Constant ack, hold 4: level cycles 1..4, done at 5, idle after.
        run("len4_ack", 4, 0, 1'b1, -1, -1, -1, 2);
        // Late ack at cycle 10, hold 3: WAIT_ACK until ack, level 1..10, done 11.
        run("len3_late", 3, 10, 1'b1, -1, -1, -1, 1);
        // hold_len 0 acts as 1.
        run("len0", 0, 0, 1'b1, -1, -1, -1, 1);
        // Ack seen only early in HOLD still releases on time.
        run("ack_early", 5, 2, 1'b0, -1, -1, -1, 1);
        // Drops in HOLD and RELEASE; clr_err coincides with the RELEASE drop.
        run("drops", 4, 0, 1'b1, 2, 5, 5, 1);
        // Clear with no concurrent drop.
        run("clear", 2, 0, 1'b1, -1, -1, 1, 1);
        // Back-to-back pulses, hold 1: second lands in HOLD and is dropped.
        run("b2b", 1, 0, 1'b1, 1, -1, -1, 0);
        run("after_b2b", 1, 0, 1'b1, -1, -1, -1, 1);
        exp_ovr = overrun;
        run("clr_b2b", 2, 0, 1'b1, -1, -1, 0, 1);

        // Reset while in WAIT_ACK: level drops immediately, done never rises.
        cyc(1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, "wrst c1");
        for (int i = 2; i <= 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0, $sformatf("wrst c%0d", i));
        #2;
        rst = 1'b1;
        #1;
        q.push_back('{1'b0, 1'b0, 1'b0});
        pop_cmp("wrst_async");
        cyc(1'b0, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, "wrst_held");
        rst = 1'b0;
        exp_ovr = 1'b0;
        run("post_rst", 2, 0, 1'b1, -1, -1, -1, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

endmodule
